// File: rtl/fp_sqrt_pre_processing_pkg.sv
// Shared FP definitions for the square-root pre-processing stage.
// State list depends on FP_SQRT_SUBNORMAL_EN (adds the NORM state).
package fp_sqrt_pre_processing_pkg;

    localparam int FLEN        = 64;
    localparam int EXPO_WIDTH  = 11;
    localparam int FRAC_WIDTH  = 52;
    localparam int ID_WIDTH    = 4;
    localparam int DATA_WIDTH  = 2 * (FRAC_WIDTH + 3);
    localparam int EXP_CALC_W  = EXPO_WIDTH + 2;
    localparam int RAD_PAD     = DATA_WIDTH - (FRAC_WIDTH + 2);
    localparam int LZC_W       = $clog2(FRAC_WIDTH);

    localparam logic signed [EXP_CALC_W-1:0] BIAS_S = 13'sd1023;
    localparam logic [FLEN-1:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef struct packed {
        logic                  sign;
        logic [EXPO_WIDTH-1:0] expo;
        logic [FRAC_WIDTH-1:0] frac;
    } fp_operand_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] radicand;
        logic [EXPO_WIDTH-1:0] expo;
    } launch_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SPECIAL,
        ST_DONE
`ifdef FP_SQRT_SUBNORMAL_EN
        , ST_NORM
`endif
    } fsm_state_t;

endpackage

// File: rtl/fp_sqrt_norm_lzc.sv
// Leading-zero counter for the subnormal fraction; result is only
// meaningful for a nonzero input.
module fp_sqrt_norm_lzc #(
    parameter int WIDTH = 52,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_sqrt_pre_processing.sv
// Square-root front end: classify, normalize, fix exponent parity, launch core.
// Define FP_SQRT_SUBNORMAL_EN to normalize subnormals instead of flushing to zero.
module fp_sqrt_pre_processing
    import fp_sqrt_pre_processing_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLEN-1:0]       rs1,
    input  logic [2:0]            rm,
    input  logic [ID_WIDTH-1:0]   id,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_radicand,
    input  logic                  core_done,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  out_special,
    output logic [FLEN-1:0]       out_special_result,
    output logic [4:0]            out_fflags,
    output logic [EXPO_WIDTH-1:0] out_expo,
    output logic [2:0]            out_rm,
    output logic [ID_WIDTH-1:0]   out_id
);

    // Odd exponents borrow one bit into the significand so the halved exponent is exact.
    function automatic launch_t build_launch(input logic [FRAC_WIDTH:0] m,
                                             input logic signed [EXP_CALC_W-1:0] e);
        launch_t l;
        logic signed [EXP_CALC_W-1:0] e_even;
        if (e[0]) begin
            l.radicand = {m, 1'b0, {RAD_PAD{1'b0}}};
            e_even     = e - 13'sd1;
        end else begin
            l.radicand = {1'b0, m, {RAD_PAD{1'b0}}};
            e_even     = e;
        end
        l.expo = EXPO_WIDTH'((e_even >>> 1) + BIAS_S);
        return l;
    endfunction

    fsm_state_t state_q, state_d;
    fp_operand_t in_op;
    logic accept;
    logic special_c;
    logic [FLEN-1:0] result_c;
    logic [4:0] fflags_c;
    logic exp_max, exp_zero, frac_zero;
    logic signed [EXP_CALC_W-1:0] e_norm;
    launch_t launch_norm;

    logic [DATA_WIDTH-1:0] radicand_q;
    logic [EXPO_WIDTH-1:0] expo_q;
    logic                  special_q;
    logic [FLEN-1:0]       result_q;
    logic [4:0]            fflags_q;
    logic [2:0]            rm_q;
    logic [ID_WIDTH-1:0]   id_q;

    assign in_op     = fp_operand_t'(rs1);
    assign exp_max   = &in_op.expo;
    assign exp_zero  = ~|in_op.expo;
    assign frac_zero = ~|in_op.frac;
    assign accept    = in_valid & in_ready;

    assign e_norm      = $signed({2'b00, in_op.expo}) - BIAS_S;
    assign launch_norm = build_launch({1'b1, in_op.frac}, e_norm);

`ifdef FP_SQRT_SUBNORMAL_EN
    logic subnorm_c;
    logic [FRAC_WIDTH-1:0] frac_q;
    logic [LZC_W-1:0] lzc;
    logic [LZC_W:0] shamt;
    logic [FRAC_WIDTH:0] m_sub;
    logic signed [EXP_CALC_W-1:0] e_sub;
    launch_t launch_sub;

    fp_sqrt_norm_lzc #(.WIDTH(FRAC_WIDTH), .CNT_W(LZC_W)) u_lzc (
        .value (frac_q),
        .count (lzc)
    );

    // Shifting one past the leading one lands it on the hidden-bit position.
    assign shamt      = {1'b0, lzc} + 7'd1;
    assign m_sub      = {1'b0, frac_q} << shamt;
    assign e_sub      = -BIAS_S - $signed({{(EXP_CALC_W-LZC_W){1'b0}}, lzc});
    assign launch_sub = build_launch(m_sub, e_sub);
`endif

    always_comb begin
        special_c = 1'b0;
        result_c  = '0;
        fflags_c  = '0;
`ifdef FP_SQRT_SUBNORMAL_EN
        subnorm_c = 1'b0;
`endif
        if (exp_max) begin
            special_c = 1'b1;
            if (!frac_zero) begin
                result_c           = CANON_NAN;
                fflags_c[FFLAG_NV] = ~in_op.frac[FRAC_WIDTH-1];
            end else if (in_op.sign) begin
                result_c           = CANON_NAN;
                fflags_c[FFLAG_NV] = 1'b1;
            end else begin
                result_c = rs1;
            end
        end else if (exp_zero && frac_zero) begin
            special_c = 1'b1;
            result_c  = rs1;
`ifndef FP_SQRT_SUBNORMAL_EN
        end else if (exp_zero) begin
            special_c = 1'b1;
            result_c  = {in_op.sign, {(FLEN-1){1'b0}}};
`endif
        end else if (in_op.sign) begin
            special_c          = 1'b1;
            result_c           = CANON_NAN;
            fflags_c[FFLAG_NV] = 1'b1;
`ifdef FP_SQRT_SUBNORMAL_EN
        end else if (exp_zero) begin
            subnorm_c = 1'b1;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (special_c) state_d = ST_SPECIAL;
`ifdef FP_SQRT_SUBNORMAL_EN
                    else if (subnorm_c) state_d = ST_NORM;
`endif
                    else state_d = ST_ISSUE;
                end
            end
`ifdef FP_SQRT_SUBNORMAL_EN
            ST_NORM:    state_d = ST_ISSUE;
`endif
            ST_ISSUE: begin
                core_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT:    if (core_done) state_d = ST_DONE;
            ST_SPECIAL: state_d = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ack) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            radicand_q <= '0;
            expo_q     <= '0;
            special_q  <= 1'b0;
            result_q   <= '0;
            fflags_q   <= '0;
            rm_q       <= '0;
            id_q       <= '0;
`ifdef FP_SQRT_SUBNORMAL_EN
            frac_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                rm_q      <= rm;
                id_q      <= id;
                special_q <= special_c;
                result_q  <= result_c;
                fflags_q  <= fflags_c;
                {radicand_q, expo_q} <= special_c ? '0 : launch_norm;
`ifdef FP_SQRT_SUBNORMAL_EN
                frac_q    <= in_op.frac;
`endif
            end
`ifdef FP_SQRT_SUBNORMAL_EN
            // Subnormal launch values replace the provisional ones from the accept cycle.
            if (state_q == ST_NORM) {radicand_q, expo_q} <= launch_sub;
`endif
        end
    end

    assign core_radicand      = radicand_q;
    assign out_special        = special_q;
    assign out_special_result = result_q;
    assign out_fflags         = fflags_q;
    assign out_expo           = expo_q;
    assign out_rm             = rm_q;
    assign out_id             = id_q;

endmodule

// File: tb/tb_fp_sqrt_pre_processing.sv
// Bench for fp_sqrt_pre_processing: directed table, random operands vs. an
// arithmetic reference model, and hand-written handshake/reset sequences.
module tb_fp_sqrt_pre_processing;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  rs1;
    logic [2:0]   rm;
    logic [3:0]   id;
    logic         core_start;
    logic [109:0] core_radicand;
    logic         core_done;
    logic         out_valid;
    logic         out_ack;
    logic         out_special;
    logic [63:0]  out_special_result;
    logic [4:0]   out_fflags;
    logic [10:0]  out_expo;
    logic [2:0]   out_rm;
    logic [3:0]   out_id;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] NAN = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic         special;
        logic [63:0]  result;
        logic [4:0]   fflags;
        logic [10:0]  expo;
        logic [109:0] radicand;
        logic [1:0]   lat;
    } exp_t;

    typedef struct packed {
        logic [63:0] op;
        exp_t        x;
    } vec_t;

    always #5 clk = ~clk;

    fp_sqrt_pre_processing dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .rs1                (rs1),
        .rm                 (rm),
        .id                 (id),
        .core_start         (core_start),
        .core_radicand      (core_radicand),
        .core_done          (core_done),
        .out_valid          (out_valid),
        .out_ack            (out_ack),
        .out_special        (out_special),
        .out_special_result (out_special_result),
        .out_fflags         (out_fflags),
        .out_expo           (out_expo),
        .out_rm             (out_rm),
        .out_id             (out_id)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t spec_res(input logic [63:0] r, input logic [4:0] f);
        exp_t x;
        x = '0;
        x.special = 1'b1;
        x.result  = r;
        x.fflags  = f;
        return x;
    endfunction

    function automatic exp_t core_res(input logic [109:0] rad, input logic [10:0] ex, input logic [1:0] lat);
        exp_t x;
        x = '0;
        x.radicand = rad;
        x.expo     = ex;
        x.lat      = lat;
        return x;
    endfunction

    // Reference: value = sig * 2^(ex-52) with sig in [2^52, 2^53); make ex even, halve it.
    function automatic exp_t model(input logic [63:0] op);
        logic        sign;
        int          e_field;
        longint      frac, sig, rad_int;
        int          ex;
        logic [109:0] rad;
        logic [1:0]  lat;
        sign    = op[63];
        e_field = int'(op[62:52]);
        frac    = longint'(op[51:0]);
        if (e_field == 2047) begin
            if (frac != 0) return spec_res(NAN, op[51] ? 5'b00000 : 5'b10000);
            if (sign) return spec_res(NAN, 5'b10000);
            return spec_res(op, 5'b00000);
        end
        if (e_field == 0 && frac == 0) return spec_res(op, 5'b00000);
`ifndef FP_SQRT_SUBNORMAL_EN
        if (e_field == 0) return spec_res({sign, 63'd0}, 5'b00000);
`endif
        if (sign) return spec_res(NAN, 5'b10000);
        if (e_field != 0) begin
            sig = (64'sd1 <<< 52) + frac;
            ex  = e_field - 1023;
            lat = 2'd1;
        end else begin
            sig = frac;
            ex  = 1 - 1023;
            lat = 2'd2;
            while (sig < (64'sd1 <<< 52)) begin
                sig = sig * 2;
                ex  = ex - 1;
            end
        end
        rad_int = sig;
        if ((ex % 2) != 0) begin
            rad_int = sig * 2;
            ex      = ex - 1;
        end
        rad = '0;
        rad[109:56] = rad_int[53:0];
        return core_res(rad, 11'(ex / 2 + 1023), lat);
    endfunction

    function automatic logic [63:0] gen_op();
        logic [10:0] e;
        logic [51:0] f;
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) e = 11'd0;
        else if (sel == 1) e = 11'h7FF;
        else e = 11'($urandom_range(1, 2046));
        f = {20'($urandom), 32'($urandom)};
        if ($urandom_range(0, 3) == 0) f = '0;
        return {($urandom_range(0, 3) == 0), e, f};
    endfunction

    // One full transaction with handshake and field checks.
    task automatic run_txn(input logic [63:0] op, input logic [2:0] r, input logic [3:0] i,
                           input exp_t x, input int done_dly, input int ack_dly, input bit early_done);
        int cyc;
        int start_cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before", in_ready, 1'b1);
        in_valid = 1'b1;
        rs1 = op;
        rm  = r;
        id  = i;
        @(negedge clk);
        in_valid = 1'b0;
        rs1 = {$urandom, $urandom};
        rm  = 3'($urandom);
        id  = 4'($urandom);
        check("busy_after_accept", in_ready, 1'b0);
        if (x.special) begin
            check("special_no_early_valid", out_valid, 1'b0);
            check("special_no_start1", core_start, 1'b0);
            @(negedge clk);
            check("special_valid_lat", out_valid, 1'b1);
            check("special_no_start2", core_start, 1'b0);
            check("special_result", out_special_result, x.result);
        end else begin
            start_cyc = 0;
            for (cyc = 1; cyc <= 6; cyc++) begin
                if (core_start || out_valid) break;
                @(negedge clk);
            end
            if (core_start) start_cyc = cyc;
            check("start_latency", start_cyc, x.lat);
            check("radicand", core_radicand, x.radicand);
            if (early_done) core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            check("start_one_cycle", core_start, 1'b0);
            check("wait_busy", in_ready, 1'b0);
            repeat (done_dly) @(negedge clk);
            check("no_valid_before_done", out_valid, 1'b0);
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            check("valid_after_done", out_valid, 1'b1);
            check("expo", out_expo, x.expo);
        end
        check("out_special", out_special, x.special);
        check("fflags", out_fflags, x.fflags);
        check("out_rm", out_rm, r);
        check("out_id", out_id, i);
        repeat (ack_dly) @(negedge clk);
        check("valid_held", out_valid, 1'b1);
        check("done_busy", in_ready, 1'b0);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("ready_after_ack", in_ready, 1'b1);
        check("valid_after_ack", out_valid, 1'b0);
    endtask

    vec_t tbl[$];

    initial begin
        logic [63:0] op;
        int stray;
        rst = 1'b1;
        in_valid = 1'b0;
        rs1 = '0;
        rm = '0;
        id = '0;
        core_done = 1'b0;
        out_ack = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_core_start", core_start, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_radicand", core_radicand, 110'd0);
        check("rst_outs", {out_special, out_special_result, out_fflags, out_expo, out_rm, out_id}, 88'd0);
        rst = 1'b0;
        @(negedge clk);

        tbl.push_back('{64'h4010_0000_0000_0000, core_res({2'b01, 108'd0}, 11'h400, 2'd1)});
        tbl.push_back('{64'h4000_0000_0000_0000, core_res({2'b10, 108'd0}, 11'h3FF, 2'd1)});
        tbl.push_back('{64'h3FF0_0000_0000_0000, core_res({2'b01, 108'd0}, 11'h3FF, 2'd1)});
        tbl.push_back('{64'h7FEF_FFFF_FFFF_FFFF, core_res({1'b1, {52{1'b1}}, 57'd0}, 11'h5FE, 2'd1)});
        tbl.push_back('{64'h0010_0000_0000_0000, core_res({2'b01, 108'd0}, 11'h200, 2'd1)});
        tbl.push_back('{64'hBFF0_0000_0000_0000, spec_res(NAN, 5'b10000)});
        tbl.push_back('{64'h7FF0_0000_0000_0001, spec_res(NAN, 5'b10000)});
        tbl.push_back('{64'h7FF8_0000_0000_0001, spec_res(NAN, 5'b00000)});
        tbl.push_back('{64'h8000_0000_0000_0000, spec_res(64'h8000_0000_0000_0000, 5'b00000)});
        tbl.push_back('{64'h0000_0000_0000_0000, spec_res(64'h0, 5'b00000)});
        tbl.push_back('{64'h7FF0_0000_0000_0000, spec_res(64'h7FF0_0000_0000_0000, 5'b00000)});
        tbl.push_back('{64'hFFF0_0000_0000_0000, spec_res(NAN, 5'b10000)});
`ifdef FP_SQRT_SUBNORMAL_EN
        tbl.push_back('{64'h0000_0000_0000_0001, core_res({2'b01, 108'd0}, 11'h1E6, 2'd2)});
        tbl.push_back('{64'h0008_0000_0000_0000, core_res({2'b10, 108'd0}, 11'h1FF, 2'd2)});
        tbl.push_back('{64'h8000_0000_0000_0001, spec_res(NAN, 5'b10000)});
`else
        tbl.push_back('{64'h0000_0000_0000_0001, spec_res(64'h0, 5'b00000)});
        tbl.push_back('{64'h0008_0000_0000_0000, spec_res(64'h0, 5'b00000)});
        tbl.push_back('{64'h8000_0000_0000_0001, spec_res(64'h8000_0000_0000_0000, 5'b00000)});
`endif
        for (int k = 0; k < tbl.size(); k++)
            run_txn(tbl[k].op, 3'(k), 4'(k + 3), tbl[k].x, k % 3 + 1, k % 2, k == 0);

        for (int k = 0; k < 60; k++) begin
            op = gen_op();
            run_txn(op, 3'($urandom), 4'($urandom), model(op),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
        end

        // in_valid held high across a whole transaction, then a second operand behind it
        in_valid = 1'b1;
        rs1 = 64'h4000_0000_0000_0000;
        rm = 3'd5;
        id = 4'd9;
        @(negedge clk);
        rs1 = 64'h8000_0000_0000_0000;
        check("b2b_start", core_start, 1'b1);
        check("b2b_busy1", in_ready, 1'b0);
        @(negedge clk);
        check("b2b_busy2", in_ready, 1'b0);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_expo", out_expo, 11'h3FF);
        check("b2b_busy3", in_ready, 1'b0);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("b2b_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_second_accepted", in_ready, 1'b0);
        @(negedge clk);
        check("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second_result", out_special_result, 64'h8000_0000_0000_0000);
        check("b2b_second_special", out_special, 1'b1);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;

        // asynchronous reset while the core is running
        in_valid = 1'b1;
        rs1 = 64'h4010_0000_0000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstw_start", core_start, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstw_ready", in_ready, 1'b1);
        check("rstw_valid", out_valid, 1'b0);
        check("rstw_radicand", core_radicand, 110'd0);
        stray = 0;
        @(negedge clk);
        if (core_start) stray++;
        rst = 1'b0;
        core_done = 1'b1;
        out_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (core_start) stray++;
            core_done = 1'b0;
            out_ack = 1'b0;
        end
        check("rstw_no_stray_start", stray, 0);
        check("idle_ignores_done_ack", {in_ready, out_valid}, 2'b10);
        run_txn(64'h4000_0000_0000_0000, 3'd1, 4'd2, model(64'h4000_0000_0000_0000), 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
